// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared types and constants for the BCD-to-binary converter.
//            Holds the converter state encoding, the BCD digit width and a
//            helper returning the binary result width for a digit count.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   // Smallest width that holds every value 0 .. 10**digits-1.
   function automatic int bin_width(input int digits);
      return $clog2(10 ** digits);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_bin_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_if
// Purpose  : Request/result handshake bundle for the BCD-to-binary converter.
// Signals  : in_valid/in_ready/bcd_in   - request channel (packed BCD)
//            out_valid/out_ready        - result channel handshake
//            bin_out/err                - result payload
// Modports : master - request producer / result consumer
//            slave  - the converter
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_to_bin_if #(
   parameter int DIGITS = 2
);
   import bcd_pkg::*;

   localparam int BIN_W = bin_width(DIGITS);

   logic                        in_valid;
   logic                        in_ready;
   logic [DIGIT_W*DIGITS-1:0]   bcd_in;
   logic                        out_valid;
   logic                        out_ready;
   logic [BIN_W-1:0]            bin_out;
   logic                        err;

   modport master (
      output in_valid, bcd_in, out_ready,
      input  in_ready, out_valid, bin_out, err
   );

   modport slave (
      input  in_valid, bcd_in, out_ready,
      output in_ready, out_valid, bin_out, err
   );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_mac.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_mac
// Purpose  : Combinational acc*10 + digit, result wrapped to BIN_W bits.
// Ports    : acc    in  BIN_W    running accumulator
//            digit  in  DIGIT_W  next BCD digit (used as-is, even if > 9)
//            result out BIN_W    (acc*10 + digit) mod 2**BIN_W
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_mac
   import bcd_pkg::*;
#(
   parameter int BIN_W = 7
) (
   input  logic [BIN_W-1:0]   acc,
   input  logic [DIGIT_W-1:0] digit,
   output logic [BIN_W-1:0]   result
);

   // x10 as x8 + x2; every term is BIN_W wide so the sum wraps naturally.
   logic [BIN_W-1:0] acc_x8;
   logic [BIN_W-1:0] acc_x2;
   logic [BIN_W-1:0] digit_ext;

   assign acc_x8    = acc << 3;
   assign acc_x2    = acc << 1;
   assign digit_ext = BIN_W'(digit);
   assign result    = acc_x8 + acc_x2 + digit_ext;

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Purpose  : Converts a packed BCD number of DIGITS digits to binary, one
//            digit per clock, most-significant digit first.
// Ports    : clk    in   single clock, rising edge
//            rst_n  in   asynchronous active-low reset
//            bus    slave modport of bcd_to_bin_if:
//                   in_valid/in_ready/bcd_in    request
//                   out_valid/out_ready         result handshake
//                   bin_out/err                 registered result
// Config   : BCD_TO_BIN_CHECK_EN - when defined, a captured nibble > 9 sets
//            err and forces bin_out to 0; otherwise err is always 0 and
//            such nibbles are used arithmetically as-is.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   bcd_to_bin_if.slave  bus
);

   localparam int BIN_W = bin_width(DIGITS);
   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t               state;
   state_t               state_nx;

   logic [BCD_W-1:0]     bcd_q;
   logic [BIN_W-1:0]     acc;
   logic [CNT_W-1:0]     cnt;
   logic [BIN_W-1:0]     bin_q;
   logic                 err_q;

   logic [DIGIT_W-1:0]   digit;
   logic [BIN_W-1:0]     mac_out;
   logic                 accept;
   logic                 last_digit;
   logic                 bad;

   assign accept     = (state == IDLE) && bus.in_valid;
   assign last_digit = (cnt == CNT_W'(DIGITS - 1));

   // Digit for this CONV cycle: cnt=0 picks the top nibble.
   always_comb begin
      digit = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (cnt == CNT_W'(DIGITS - 1 - i)) begin
            digit = bcd_q[i*DIGIT_W +: DIGIT_W];
         end
      end
   end

`ifdef BCD_TO_BIN_CHECK_EN
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) begin
            bad = 1'b1;
         end
      end
   end
`else
   assign bad = 1'b0;
`endif

   bcd_digit_mac #(
      .BIN_W  (BIN_W)
   ) u_mac (
      .acc    (acc),
      .digit  (digit),
      .result (mac_out)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nx = CONV;
         CONV:    if (last_digit)    state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   // The result register is loaded on the last CONV edge so it is already
   // valid when DONE is entered and then holds until the next conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q <= '0;
         acc   <= '0;
         cnt   <= '0;
         bin_q <= '0;
         err_q <= 1'b0;
      end else if (accept) begin
         bcd_q <= bus.bcd_in;
         acc   <= '0;
         cnt   <= '0;
      end else if (state == CONV) begin
         acc <= mac_out;
         cnt <= cnt + CNT_W'(1);
         if (last_digit) begin
            bin_q <= bad ? '0 : mac_out;
            err_q <= bad;
         end
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.bin_out   = bin_q;
   assign bus.err       = err_q;

endmodule
`default_nettype wire
